// File: rtl/mp_add_seq.sv
// Multi-precision add/subtract sequencer: one WORD_W-bit adder stepped across WORDS
// words per transaction, LSW first, with the inter-word carry held in a register.
module mp_add_seq #(
  parameter int WORD_W = 64,
  parameter int WORDS  = 4,
  parameter int IDX_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [WORD_W-1:0] op_a,
  input  logic [WORD_W-1:0] op_b,
  input  logic              op_sub,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [WORD_W-1:0] res_sum,
  output logic              res_cout,
  output logic [IDX_W-1:0]  res_idx,
  output logic              res_last,
  output logic              busy,
  output logic              dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid never depends on ready, and a held result keeps every res_* bit stable until taken.
  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t              r_state;
  logic [IDX_W-1:0]    r_idx;
  logic                r_carry;
  logic                r_mode;
  logic                r_res_valid;
  logic [WORD_W-1:0]   r_res_sum;
  logic                r_res_cout;
  logic [IDX_W-1:0]    r_res_idx;
  logic                r_res_last;

  logic                w_accept;
  logic                w_first;
  logic                w_last;
  logic                w_mode;
  logic                w_cin;
  logic [WORD_W-1:0]   w_b_eff;
  logic [WORD_W:0]     w_full;

  assign op_ready = ~rst & (~r_res_valid | res_ready);
  assign w_accept = op_valid & op_ready;
  assign w_first  = (r_idx == '0);
  assign w_last   = (r_idx == IDX_W'(WORDS - 1));

  // Word 0 takes its mode and carry-in straight from op_sub; later words use the latched copy.
  assign w_mode  = w_first ? op_sub : r_mode;
  assign w_cin   = w_first ? op_sub : r_carry;
  assign w_b_eff = w_mode ? ~op_b : op_b;
  assign w_full  = {1'b0, op_a} + {1'b0, w_b_eff} + (WORD_W + 1)'(w_cin);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_carry     <= 1'b0;
      r_mode      <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_sum   <= '0;
      r_res_cout  <= 1'b0;
      r_res_idx   <= '0;
      r_res_last  <= 1'b0;
    end else if (w_accept) begin
      r_res_valid <= 1'b1;
      r_res_sum   <= w_full[WORD_W-1:0];
      r_res_cout  <= w_full[WORD_W];
      r_res_idx   <= r_idx;
      r_res_last  <= w_last;
      r_carry     <= w_full[WORD_W];
      if (w_first) begin
        r_mode <= op_sub;
      end
      if (w_last) begin
        r_idx   <= '0;
        r_state <= S_IDLE;
      end else begin
        r_idx   <= r_idx + IDX_W'(1);
        r_state <= S_RUN;
      end
    end else if (res_ready) begin
      r_res_valid <= 1'b0;
    end
  end

  assign res_valid = r_res_valid;
  assign res_sum   = r_res_sum;
  assign res_cout  = r_res_cout;
  assign res_idx   = r_res_idx;
  assign res_last  = r_res_last;
  assign busy      = (r_state == S_RUN) | r_res_valid;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mp_add_seq.sv
// Bench for mp_add_seq: directed and random transactions scored against a
// whole-operand arithmetic model that predicts every result word.
module tb_mp_add_seq;

  localparam int W     = 64;
  localparam int WORDS = 4;
  localparam int IDX_W = 2;
  localparam int TW    = W * WORDS;
  localparam int EW    = 1 + IDX_W + 1 + W;

  logic             clk = 1'b0;
  logic             rst;
  logic             op_valid;
  logic             op_ready;
  logic [W-1:0]     op_a;
  logic [W-1:0]     op_b;
  logic             op_sub;
  logic             res_valid;
  logic             res_ready;
  logic [W-1:0]     res_sum;
  logic             res_cout;
  logic [IDX_W-1:0] res_idx;
  logic             res_last;
  logic             busy;
  logic             dbg_state;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] obs_q[$];
  int            obs_t_q[$];

  mp_add_seq #(.WORD_W(W), .WORDS(WORDS), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b), .op_sub(op_sub),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_sum(res_sum), .res_cout(res_cout), .res_idx(res_idx),
    .res_last(res_last), .busy(busy), .dbg_state(dbg_state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: a result is consumed at the edge following a negedge where valid & ready.
  always @(negedge clk) begin
    if (res_valid === 1'b1 && res_ready === 1'b1) begin
      obs_q.push_back({res_last, res_idx, res_cout, res_sum});
      obs_t_q.push_back(cyc);
    end
  end

  // Reference model: whole-operand arithmetic; word i carry is the carry out of the low (i+1) words.
  task automatic model_push(input logic [TW-1:0] a, input logic [TW-1:0] b, input logic sub,
                            input int n);
    logic [TW-1:0] beff;
    logic [TW:0]   m;
    logic [TW:0]   low;
    beff = sub ? ~b : b;
    for (int i = 0; i < n; i++) begin
      m   = ((TW + 1)'(1) << ((i + 1) * W)) - (TW + 1)'(1);
      low = ({1'b0, a} & m) + ({1'b0, beff} & m) + (TW + 1)'(sub);
      exp_q.push_back({(i == WORDS - 1), IDX_W'(i), low[(i + 1) * W], low[i * W +: W]});
    end
  endtask

  // Driver: present one word pair and return one cycle after it is accepted.
  task automatic send_word(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    int n = 0;
    op_valid = 1'b1; op_a = a; op_b = b; op_sub = sub;
    @(negedge clk);
    while (op_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (op_ready !== 1'b1) begin
      errors++; checks++;
      $display("FAIL accept_timeout: op_ready=%b required 1 within 50 cycles", op_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic drive_txn(input logic [TW-1:0] a, input logic [TW-1:0] b, input logic sub,
                           input logic toggle, input int n);
    for (int i = 0; i < n; i++)
      send_word(a[i * W +: W], b[i * W +: W], (toggle && i == 1) ? ~sub : sub);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (obs_q.size() < exp_q.size() && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
  endtask

  function automatic logic [TW-1:0] rand_wide();
    logic [TW-1:0] v;
    for (int i = 0; i < WORDS; i++)
      v[i * W +: W] = ($urandom_range(0, 3) == 0) ? {W{1'b1}} : {$urandom, $urandom};
    return v;
  endfunction

  task automatic test_reset();
    rst = 1'b1; op_valid = 1'b0; op_a = '0; op_b = '0; op_sub = 1'b0; res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({res_valid, res_sum, res_cout, res_idx, res_last, busy, dbg_state} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b sum=%h cout=%b idx=%0d last=%b busy=%b state=%b required all 0",
               res_valid, res_sum, res_cout, res_idx, res_last, busy, dbg_state);
    end
    checks++;
    if (op_ready !== 1'b0) begin
      errors++; $display("FAIL reset_op_ready: got %b required 0", op_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (op_ready !== 1'b1) begin
      errors++; $display("FAIL ready_after_reset: got %b required 1", op_ready);
    end
  endtask

  task automatic test_directed(input string name, input logic [TW-1:0] a, input logic [TW-1:0] b,
                               input logic sub);
    logic [EW-1:0] e, o;
    model_push(a, b, sub, WORDS);
    drive_txn(a, b, sub, 1'b0, WORDS);
    op_valid = 1'b0;
    wait_drain();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s count: got %0d words required %0d", name, obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); void'(obs_t_q.pop_front());
      checks++;
      if (o !== e) begin
        errors++; $display("FAIL %s word: got %h required %h", name, o, e);
      end
    end
    checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin
      errors++; $display("FAIL %s idle_after: busy=%b valid=%b required 0 0", name, busy, res_valid);
    end
    exp_q.delete(); obs_q.delete(); obs_t_q.delete();
  endtask

  task automatic test_backpressure();
    logic [TW-1:0] a, b;
    logic [W-1:0]  s;
    logic [IDX_W-1:0] ix;
    logic [EW-1:0] e, o;
    int n = 0;
    a = rand_wide(); b = rand_wide();
    model_push(a, b, 1'b0, WORDS);
    res_ready = 1'b0;
    fork
      begin
        drive_txn(a, b, 1'b0, 1'b0, WORDS);
        op_valid = 1'b0;
      end
      begin
        @(negedge clk);
        while (res_valid !== 1'b1 && n < 20) begin
          @(negedge clk);
          n++;
        end
        s = res_sum; ix = res_idx;
        for (int k = 0; k < 3; k++) begin
          checks++;
          if (op_ready !== 1'b0 || res_valid !== 1'b1 || res_sum !== s || res_idx !== ix) begin
            errors++;
            $display("FAIL stall_hold cycle %0d: ready=%b valid=%b sum=%h idx=%0d required 0 1 %h %0d",
                     k, op_ready, res_valid, res_sum, res_idx, s, ix);
          end
          if (k < 2) @(negedge clk);
        end
        @(posedge clk); #2;
        res_ready = 1'b1;
      end
    join
    wait_drain();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL backpressure count: got %0d words required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); void'(obs_t_q.pop_front());
      checks++;
      if (o !== e) begin
        errors++; $display("FAIL backpressure word: got %h required %h", o, e);
      end
    end
    exp_q.delete(); obs_q.delete(); obs_t_q.delete();
  endtask

  task automatic test_reset_mid();
    logic [TW-1:0] a, b;
    logic [EW-1:0] e, o;
    a = rand_wide(); b = rand_wide();
    model_push(a, b, 1'b1, 2);
    drive_txn(a, b, 1'b1, 1'b0, 2);
    op_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({res_valid, res_sum, res_cout, res_idx, res_last, busy} !== '0 || op_ready !== 1'b0) begin
      errors++;
      $display("FAIL midreset_outputs: valid=%b sum=%h cout=%b idx=%0d last=%b busy=%b ready=%b required all 0",
               res_valid, res_sum, res_cout, res_idx, res_last, busy, op_ready);
    end
    rst = 1'b0;
    a = '0; b = '0; a[W-1:0] = 64'd5; b[W-1:0] = 64'd3;
    model_push(a, b, 1'b0, WORDS);
    drive_txn(a, b, 1'b0, 1'b0, WORDS);
    op_valid = 1'b0;
    wait_drain();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL midreset count: got %0d words required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); void'(obs_t_q.pop_front());
      checks++;
      if (o !== e) begin
        errors++; $display("FAIL midreset word: got %h required %h", o, e);
      end
    end
    exp_q.delete(); obs_q.delete(); obs_t_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [TW-1:0] a0, b0, a1, b1;
    logic [EW-1:0] e, o;
    int t, tp;
    a0 = rand_wide(); b0 = rand_wide(); a1 = rand_wide(); b1 = rand_wide();
    model_push(a0, b0, 1'b0, WORDS);
    model_push(a1, b1, 1'b1, WORDS);
    drive_txn(a0, b0, 1'b0, 1'b1, WORDS);
    drive_txn(a1, b1, 1'b1, 1'b1, WORDS);
    op_valid = 1'b0;
    wait_drain();
    checks++;
    if (obs_q.size() != 2 * WORDS) begin
      errors++; $display("FAIL b2b count: got %0d words required %0d", obs_q.size(), 2 * WORDS);
    end
    tp = -1;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = obs_t_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++; $display("FAIL b2b word: got %h required %h", o, e);
      end
      if (tp >= 0) begin
        checks++;
        if (t != tp + 1) begin
          errors++; $display("FAIL b2b spacing: result at cycle %0d required %0d", t, tp + 1);
        end
      end
      tp = t;
    end
    exp_q.delete(); obs_q.delete(); obs_t_q.delete();
  endtask

  task automatic test_random();
    logic [TW-1:0] a, b;
    logic          sub;
    logic [EW-1:0] e, o;
    logic          done = 1'b0;
    fork
      begin
        for (int t = 0; t < 12; t++) begin
          a = rand_wide(); b = rand_wide(); sub = 1'($urandom_range(0, 1));
          model_push(a, b, sub, WORDS);
          drive_txn(a, b, sub, 1'($urandom_range(0, 1)), WORDS);
          if ($urandom_range(0, 2) == 0) begin
            op_valid = 1'b0;
            @(posedge clk); #1;
          end
        end
        op_valid = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #2;
          res_ready = ($urandom_range(0, 3) != 0);
        end
        res_ready = 1'b1;
      end
    join
    wait_drain();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL random count: got %0d words required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); void'(obs_t_q.pop_front());
      checks++;
      if (o !== e) begin
        errors++; $display("FAIL random word: got %h required %h", o, e);
      end
    end
    exp_q.delete(); obs_q.delete(); obs_t_q.delete();
  endtask

  initial begin
    logic [TW-1:0] a, b;
    test_reset();
    a = '0; b = '0;
    a[2*W-1:0] = {2{64'hFFFF_FFFF_FFFF_FFFF}}; b[W-1:0] = 64'd1;
    test_directed("add_ripple", a, b, 1'b0);
    a = '0; b = '0; b[W-1:0] = 64'd1;
    test_directed("sub_borrow", a, b, 1'b1);
    a = '1; b = '1;
    test_directed("add_overflow", a, b, 1'b0);
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
